// File: rtl/alu_wb_queue_pkg.sv
// Shared ALU definitions: control encodings, flag bit positions and trap classification.
// Used by the ALU, its control decoder and the writeback queue.
package alu_wb_queue_pkg;

  typedef enum logic [3:0] {
    AluAnd  = 4'b0000,
    AluOr   = 4'b0001,
    AluAdd  = 4'b0010,
    AluSub  = 4'b0110,
    AluSlt  = 4'b0111,
    AluNor  = 4'b1100,
    AluNand = 4'b1101
  } alu_ctrl_e;

  localparam int unsigned FLAG_ZERO = 0;
  localparam int unsigned FLAG_COUT = 1;
  localparam int unsigned FLAG_OVF  = 2;
  localparam int unsigned FLAGS_W   = 3;

  // Only arithmetic ops raise a trap on signed overflow.
  function automatic logic trap_en_for(alu_ctrl_e ctrl);
    return (ctrl == AluAdd) || (ctrl == AluSub);
  endfunction

endpackage

// File: rtl/wbq_fifo_mem.sv
// Writeback queue storage: registered write port, combinational read port.
// Contents are intentionally not reset.
module wbq_fifo_mem #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 40
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];

  always_comb begin
    mem_d = mem_q;
    if (we) begin
      mem_d[waddr] = wdata;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/alu_wb_queue.sv
// Writeback queue between the ALU and the register-file write port.
// Drops trapping overflows into a sticky exception record and discards writes to r0.
module alu_wb_queue
  import alu_wb_queue_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        in_result,
  input  logic                     in_zero,
  input  logic                     in_cout,
  input  logic                     in_overflow,
  input  logic [ADDR_W-1:0]        in_rd,
  input  logic                     in_trap_en,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_result,
  output logic [ADDR_W-1:0]        out_rd,
  output logic [2:0]               out_flags,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     exc_sticky,
  output logic [ADDR_W-1:0]        exc_rd,
  input  logic                     exc_clr
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned EW = DATA_W + ADDR_W + FLAGS_W;
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [AW:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic              exc_sticky_q, exc_sticky_d;
  logic [ADDR_W-1:0] exc_rd_q, exc_rd_d;

  logic          full, empty, accept, trap, push, pop;
  logic [2:0]    in_flags;
  logic [EW-1:0] wdata, rdata;

  assign count    = wr_ptr_q - rd_ptr_q;
  assign full     = (count == FULL_CNT);
  assign empty    = (count == '0);
  assign in_ready = rst_n && !full;
  assign accept   = in_valid && in_ready;
  assign trap     = accept && in_overflow && in_trap_en;
  assign push     = accept && !trap && (in_rd != '0);
  assign pop      = out_valid && out_ready;

  always_comb begin
    in_flags            = '0;
    in_flags[FLAG_ZERO] = in_zero;
    in_flags[FLAG_COUT] = in_cout;
    in_flags[FLAG_OVF]  = in_overflow;
  end

  assign wdata = {in_result, in_rd, in_flags};

  wbq_fifo_mem #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr_q[AW-1:0]),
    .wdata (wdata),
    .raddr (rd_ptr_q[AW-1:0]),
    .rdata (rdata)
  );

  assign out_valid  = !empty;
  assign out_result = out_valid ? rdata[EW-1 -: DATA_W]    : '0;
  assign out_rd     = out_valid ? rdata[FLAGS_W +: ADDR_W] : '0;
  assign out_flags  = out_valid ? rdata[FLAGS_W-1:0]       : '0;

  always_comb begin
    wr_ptr_d     = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d     = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    exc_sticky_d = exc_sticky_q;
    exc_rd_d     = exc_rd_q;
    // A new trap beats a same-cycle clear and then records its own index.
    if (trap) begin
      exc_sticky_d = 1'b1;
      if (!exc_sticky_q || exc_clr) begin
        exc_rd_d = in_rd;
      end
    end else if (exc_clr) begin
      exc_sticky_d = 1'b0;
      exc_rd_d     = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      exc_sticky_q <= 1'b0;
      exc_rd_q     <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      exc_sticky_q <= exc_sticky_d;
      exc_rd_q     <= exc_rd_d;
    end
  end

  assign exc_sticky = exc_sticky_q;
  assign exc_rd     = exc_rd_q;

endmodule

// File: tb/tb_alu_wb_queue.sv
// Directed and random checks of alu_wb_queue against a queue-based reference model.
module tb_alu_wb_queue;
  import alu_wb_queue_pkg::*;

  localparam int unsigned DEPTH = 4;

  typedef struct packed {
    logic [31:0] res;
    logic [4:0]  rd;
    logic [2:0]  flags;
  } entry_t;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, in_zero, in_cout, in_overflow, in_trap_en;
  logic [31:0] in_result, out_result;
  logic [4:0]  in_rd, out_rd, exc_rd;
  logic        out_valid, out_ready, exc_sticky, exc_clr;
  logic [2:0]  out_flags;
  logic [2:0]  count;

  entry_t     mq[$];
  logic       m_sticky;
  logic [4:0] m_rd;
  int         tests = 0;
  int         fails = 0;

  always #5 clk = ~clk;

  alu_wb_queue #(
    .DATA_W (32),
    .ADDR_W (5),
    .DEPTH  (DEPTH)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_result   (in_result),
    .in_zero     (in_zero),
    .in_cout     (in_cout),
    .in_overflow (in_overflow),
    .in_rd       (in_rd),
    .in_trap_en  (in_trap_en),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_result  (out_result),
    .out_rd      (out_rd),
    .out_flags   (out_flags),
    .count       (count),
    .exc_sticky  (exc_sticky),
    .exc_rd      (exc_rd),
    .exc_clr     (exc_clr)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    tests++;
    assert (obs === exp_v) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  task automatic check_all();
    entry_t head;
    head = (mq.size() > 0) ? mq[0] : '0;
    chk("in_ready",   64'(in_ready),   64'(rst_n && (mq.size() < DEPTH)));
    chk("out_valid",  64'(out_valid),  64'(mq.size() > 0));
    chk("out_result", 64'(out_result), 64'(head.res));
    chk("out_rd",     64'(out_rd),     64'(head.rd));
    chk("out_flags",  64'(out_flags),  64'(head.flags));
    chk("count",      64'(count),      64'(mq.size()));
    chk("exc_sticky", 64'(exc_sticky), 64'(m_sticky));
    chk("exc_rd",     64'(exc_rd),     64'(m_rd));
  endtask

  // Called at a falling edge with inputs already driven; advances one cycle.
  task automatic cycle();
    logic   acc, trap, push, pop;
    entry_t e;
    acc  = in_valid && rst_n && (mq.size() < DEPTH);
    trap = acc && in_overflow && in_trap_en;
    push = acc && !trap && (in_rd != 5'd0);
    pop  = (mq.size() > 0) && out_ready;
    e    = '{res: in_result, rd: in_rd, flags: {in_overflow, in_cout, in_zero}};
    @(posedge clk);
    if (!rst_n) begin
      mq.delete();
      m_sticky = 1'b0;
      m_rd     = 5'd0;
    end else begin
      if (pop) void'(mq.pop_front());
      if (push) mq.push_back(e);
      if (trap) begin
        if (!m_sticky || exc_clr) m_rd = in_rd;
        m_sticky = 1'b1;
      end else if (exc_clr) begin
        m_sticky = 1'b0;
        m_rd     = 5'd0;
      end
    end
    @(negedge clk);
    check_all();
  endtask

  task automatic put(input logic v, input logic [31:0] res, input logic [4:0] rd,
                     input logic ovf, input logic trap_en);
    in_valid    = v;
    in_result   = res;
    in_rd       = rd;
    in_overflow = ovf;
    in_trap_en  = trap_en;
    in_zero     = (res == 32'd0);
    in_cout     = 1'b0;
  endtask

  initial begin
    alu_ctrl_e ctrls[7];
    ctrls = '{AluAnd, AluOr, AluAdd, AluSub, AluSlt, AluNor, AluNand};
    m_sticky  = 1'b0;
    m_rd      = 5'd0;
    rst_n     = 1'b0;
    out_ready = 1'b0;
    exc_clr   = 1'b0;
    put(1'b0, 32'd0, 5'd0, 1'b0, 1'b0);
    cycle();
    cycle();
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    rst_n = 1'b1;
    cycle();
    chk("rel_in_ready", 64'(in_ready), 64'd1);

    // Single entry, one-cycle latency, then pop.
    put(1'b1, 32'h5, 5'd3, 1'b0, 1'b0);
    cycle();
    chk("single_valid", 64'(out_valid), 64'd1);
    chk("single_res", 64'(out_result), 64'h5);
    chk("single_rd", 64'(out_rd), 64'd3);
    chk("single_cnt", 64'(count), 64'd1);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    cycle();
    chk("pop_cnt", 64'(count), 64'd0);
    chk("pop_res0", 64'(out_result), 64'd0);

    // Fill, overflow attempt, drain in order; repeated for pointer wrap.
    for (int rep = 0; rep < 3; rep++) begin
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
        put(1'b1, 32'h10 + 32'(i), 5'(i + 1), 1'b0, 1'b0);
        cycle();
      end
      chk("full_ready", 64'(in_ready), 64'd0);
      chk("full_cnt", 64'(count), 64'd4);
      put(1'b1, 32'h99, 5'd7, 1'b0, 1'b0);
      cycle();
      chk("fifth_cnt", 64'(count), 64'd4);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
        chk("drain_order", 64'(out_result), 64'h10 + 64'(i));
        cycle();
      end
      chk("drain_cnt", 64'(count), 64'd0);
    end

    // Trapping overflows: first index sticks, clear empties the record.
    out_ready = 1'b0;
    put(1'b1, 32'h8000_0000, 5'd8, 1'b1, trap_en_for(AluAdd));
    cycle();
    put(1'b1, 32'h8000_0000, 5'd9, 1'b1, trap_en_for(AluAdd));
    cycle();
    chk("trap_cnt", 64'(count), 64'd0);
    chk("trap_sticky", 64'(exc_sticky), 64'd1);
    chk("trap_rd", 64'(exc_rd), 64'd8);
    in_valid = 1'b0;
    exc_clr  = 1'b1;
    cycle();
    chk("clr_sticky", 64'(exc_sticky), 64'd0);
    chk("clr_rd", 64'(exc_rd), 64'd0);

    // Clear and trap together: set wins with the new index.
    put(1'b1, 32'h8000_0000, 5'd12, 1'b1, trap_en_for(AluSub));
    exc_clr = 1'b1;
    cycle();
    exc_clr = 1'b0;
    chk("clrset_sticky", 64'(exc_sticky), 64'd1);
    chk("clrset_rd", 64'(exc_rd), 64'd12);

    // r0 discard; non-trapping overflow is enqueued with its flag.
    put(1'b1, 32'hFFFF_FFFF, 5'd0, 1'b0, 1'b0);
    cycle();
    chk("r0_cnt", 64'(count), 64'd0);
    put(1'b1, 32'h1, 5'd5, 1'b1, trap_en_for(AluSlt));
    cycle();
    chk("slt_cnt", 64'(count), 64'd1);
    chk("slt_flags", 64'(out_flags), 64'b100);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    cycle();

    // Simultaneous push/pop at count 2, then reset mid-operation.
    out_ready = 1'b0;
    put(1'b1, 32'h21, 5'd1, 1'b0, 1'b0);
    cycle();
    put(1'b1, 32'h22, 5'd2, 1'b0, 1'b0);
    cycle();
    out_ready = 1'b1;
    put(1'b1, 32'h23, 5'd3, 1'b0, 1'b0);
    cycle();
    chk("pp_cnt", 64'(count), 64'd2);
    chk("pp_head", 64'(out_result), 64'h22);
    out_ready = 1'b0;
    put(1'b1, 32'h24, 5'd4, 1'b0, 1'b0);
    cycle();
    chk("pre_rst_cnt", 64'(count), 64'd3);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    cycle();
    chk("rst_cnt", 64'(count), 64'd0);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_sticky", 64'(exc_sticky), 64'd0);
    rst_n = 1'b1;
    cycle();

    // Random traffic against the model.
    for (int n = 0; n < 600; n++) begin
      alu_ctrl_e c;
      c = ctrls[$urandom_range(0, 6)];
      put(1'($urandom_range(0, 3) != 0), $urandom(), 5'($urandom_range(0, 31)),
          1'($urandom_range(0, 3) == 0), trap_en_for(c));
      if ($urandom_range(0, 7) == 0) in_rd = 5'd0;
      in_cout   = 1'($urandom_range(0, 1));
      in_zero   = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 2) == 0);
      exc_clr   = 1'($urandom_range(0, 15) == 0);
      rst_n     = 1'($urandom_range(0, 63) != 0);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_wb_queue.md
# alu_wb_queue

Writeback queue directly downstream of the 32-bit ALU. Each cycle it captures one ALU result with its flags (zero, cout, overflow) and a destination register index, buffers it in a small FIFO, and presents it to the register-file write port with a valid/ready handshake. Results that raise a trapping overflow are dropped and recorded in a sticky exception register. Writes to register 0 are discarded.

## Interface
Parameters:
- DATA_W, 32, result width
- ADDR_W, 5, destination register index width
- DEPTH, 4, FIFO entries; power of two, minimum 2

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  reset rst_n, synchronous, active-low
- in_valid  in  1  ALU result valid this cycle
- in_ready  out  1  queue can accept; equals !full, forced 0 while rst_n=0
- in_result  in  DATA_W  ALU result
- in_zero  in  1  ALU zero flag
- in_cout  in  1  ALU carry out
- in_overflow  in  1  ALU signed overflow
- in_rd  in  ADDR_W  destination register index
- in_trap_en  in  1  overflow on this op traps (add/sub); 0 for and/or/nor/nand/slt
- out_valid  out  1  head entry present
- out_ready  in  1  register file accepts head
- out_result  out  DATA_W  head result; 0 when empty
- out_rd  out  ADDR_W  head index; 0 when empty
- out_flags  out  3  head {overflow, cout, zero}; 0 when empty
- count  out  $clog2(DEPTH)+1  occupied entries
- exc_sticky  out  1  trapping overflow seen since last clear
- exc_rd  out  ADDR_W  in_rd of the first trapping op since last clear
- exc_clr  in  1  clear exc_sticky and exc_rd

## Operation
- Accept: in_valid && in_ready.
- Classification of an accepted input:
  - in_overflow && in_trap_en: trap. Not enqueued. exc_sticky <= 1. exc_rd <= in_rd only if exc_sticky was 0.
  - Otherwise, if in_rd == 0: dropped silently.
  - Otherwise: enqueued at the write pointer as {result, rd, overflow, cout, zero}.
- Pop: out_valid && out_ready advances the read pointer.
- Pointers are ADDR bits plus one wrap bit. full = count == DEPTH; empty = count == 0.
- Simultaneous push and pop when not full: both occur and count is unchanged.
- When full, in_ready = 0, so no push occurs even with a same-cycle pop. There is no pass-through.
- exc_clr and a new trap in the same cycle: the set wins, and exc_rd takes the new in_rd.
- Non-trapping overflow (in_trap_en=0) is enqueued normally, with overflow=1 in out_flags.

## Timing
- Reset values (rst_n=0 at an edge):
  - pointers 0, count 0
  - out_valid 0, out_result/out_rd/out_flags 0
  - exc_sticky 0, exc_rd 0
  - in_ready 0 while rst_n is low, 1 the cycle after release
- FIFO contents are not reset.
- Latency: an entry pushed at edge N has out_valid=1 from just after edge N. One cycle, no bypass of an empty queue.
- out_* are combinational reads of the head entry and are stable while out_valid && !out_ready.
- Reset asserted mid-operation discards all entries at that edge. No partial pop.
- count, exc_sticky, and exc_rd update on the same edge as the push or pop that causes them.

## Structure
- Shared package (used with the ALU and its control decoder):
  - ALU_control encodings: AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111, NOR 1100, NAND 1101
  - FLAG_ZERO/COUT/OVF bit positions
  - a helper that returns trap-enable for a given ALU_control (1 for ADD/SUB only)
- One sub-module, wbq_fifo_mem: DEPTH × (DATA_W+ADDR_W+3) storage with a registered write and a combinational read.
- Classification, pointers, and exception logic live in alu_wb_queue.

## Test plan
- Reset, then push {result 0x0000_0005, rd 3, flags zero=0} with out_ready=0 → next cycle out_valid=1, out_result=5, out_rd=3, count=1; raise out_ready → count=0, out_valid=0, outputs 0.
- Push 4 entries (rd 1..4, results 0x10..0x13) with out_ready=0 → in_ready=0, count=4. A fifth in_valid is ignored. Pop all four → results 0x10,0x11,0x12,0x13 in order. Repeat 3 times to exercise pointer wrap.
- Push 0x7FFF_FFFF+1 as ADD (overflow=1, trap_en=1, rd 8), then again with rd 9 → nothing enqueued, exc_sticky=1, exc_rd=8. Assert exc_clr alone → exc_sticky=0, exc_rd=0.
- Assert exc_clr in the same cycle as a trap with rd 12 → exc_sticky=1, exc_rd=12.
- Push with rd 0 (result 0xFFFF_FFFF) → count stays 0. Push SLT result 1 with overflow=1, trap_en=0, rd 5 → enqueued, out_flags=3'b100.
- With count=2, push and pop in the same cycle → count stays 2, order preserved. Assert rst_n=0 with count=3 → next cycle count=0, out_valid=0, exc_sticky=0.
